// File: rtl/permutation_iterative.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// couche_substitution
//   ASCON substitution layer p_s: the 5-bit S-box applied to each of the 64
//   bit columns of the state, written in bit-sliced form on whole 64-bit words.
//   Purely combinational.
// Ports
//   state_i  in  320  state before substitution {S_0..S_4}, S_0 = bits 319:256
//   state_o  out 320  state after substitution
// ---------------------------------------------------------------------------
module couche_substitution (
  input  logic [319:0] state_i,
  output logic [319:0] state_o
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  // NOTE: blocking assignments are correct here: this is a chain of
  // combinational steps evaluated in order, not a set of registers.
  always_comb begin
    x0 = state_i[319:256];
    x1 = state_i[255:192];
    x2 = state_i[191:128];
    x3 = state_i[127:64];
    x4 = state_i[63:0];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;

    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;

    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;

    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    state_o = {x0, x1, x2, x3, x4};
  end

endmodule

// ---------------------------------------------------------------------------
// permutation_iterative
//   Iterative ASCON permutation: one full round p_L(p_s(p_c(S))) per clock on
//   a 320-bit state register, with a round counter and start/done handshake.
//   p^a runs rounds 12-NB_ROUNDS_A..11, p^b runs rounds 12-NB_ROUNDS_B..11.
// Ports
//   clock_i   in   1    system clock, rising edge
//   resetb_i  in   1    asynchronous reset, active low
//   start_i   in   1    request a permutation, sampled only in IDLE
//   sel_b_i   in   1    0: NB_ROUNDS_A rounds, 1: NB_ROUNDS_B rounds
//   state_i   in   320  input state {S_0..S_4}, S_0 = bits 319:256
//   state_o   out  320  state register, driven continuously
//   busy_o    out  1    high while rounds are being applied (RUN)
//   done_o    out  1    one-cycle pulse, state_o holds the permuted state
// ---------------------------------------------------------------------------
module permutation_iterative #(
  parameter int NB_ROUNDS_A = 12,
  parameter int NB_ROUNDS_B = 6
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic         sel_b_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // The counter always ends on round 11; shorter permutations start later.
  localparam logic [3:0] R_FIRST_A = 4'(12 - NB_ROUNDS_A);
  localparam logic [3:0] R_FIRST_B = 4'(12 - NB_ROUNDS_B);
  localparam logic [3:0] R_LAST    = 4'd11;

  fsm_t         fsm_q, fsm_d;
  logic [319:0] state_q;
  logic [3:0]   round_q;
  logic [7:0]   round_const;
  logic [319:0] pc_state;
  logic [319:0] ps_state;
  logic [319:0] pl_state;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: fsm_d gets a default before the case so every path assigns it and
  // no latch is inferred.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (start_i) fsm_d = RUN;
      RUN:     if (round_q == R_LAST) fsm_d = DONE;
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs, decoded from the state register only
  // -------------------------------------------------------------------------
  always_comb begin
    busy_o = (fsm_q == RUN);
    done_o = (fsm_q == DONE);
  end

  // -------------------------------------------------------------------------
  // Datapath registers: state and round counter
  // -------------------------------------------------------------------------
  // NOTE: the 320-bit state is a plain flop bank (not a memory), and it is
  // cleared on reset so an aborted run leaves no partial result visible.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= '0;
      round_q <= '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start_i) begin
            state_q <= state_i;
            round_q <= sel_b_i ? R_FIRST_B : R_FIRST_A;
          end
        end
        RUN: begin
          state_q <= pl_state;
          // Counter parks on 11 after the last round; it is reloaded on start.
          if (round_q != R_LAST) round_q <= round_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // p_c: round constant into the low byte of S_2
  // -------------------------------------------------------------------------
  always_comb begin
    round_const            = {4'hF - round_q, round_q};
    pc_state               = state_q;
    pc_state[135:128]      = state_q[135:128] ^ round_const;
  end

  // -------------------------------------------------------------------------
  // p_s: substitution layer
  // -------------------------------------------------------------------------
  couche_substitution u_sbox (
    .state_i (pc_state),
    .state_o (ps_state)
  );

  // -------------------------------------------------------------------------
  // p_L: per-word linear diffusion, rotations are constant per word
  // -------------------------------------------------------------------------
  function automatic logic [63:0] rotr(input logic [63:0] w, input int n);
    return (w >> n) | (w << (64 - n));
  endfunction

  function automatic logic [63:0] diffuse(input logic [63:0] w, input int a, input int b);
    return w ^ rotr(w, a) ^ rotr(w, b);
  endfunction

  assign pl_state = {diffuse(ps_state[319:256], 19, 28),
                     diffuse(ps_state[255:192], 61, 39),
                     diffuse(ps_state[191:128],  1,  6),
                     diffuse(ps_state[127:64],  10, 17),
                     diffuse(ps_state[63:0],     7, 41)};

  assign state_o = state_q;

endmodule

// File: tb/tb_permutation_iterative.sv
`timescale 1ns/1ps
// Self-checking bench for permutation_iterative. A transaction-level model
// (table S-box, word-wise linear layer, elapsed-cycle schedule) predicts
// busy/done/state every cycle; directed scenarios add latency, probe and
// reset checks on top.
module tb_permutation_iterative;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sel_b = 1'b0;
  logic [319:0] state_in = '0;
  logic [319:0] state_out;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  permutation_iterative dut (
    .clock_i  (clk),
    .resetb_i (rst_n),
    .start_i  (start),
    .sel_b_i  (sel_b),
    .state_i  (state_in),
    .state_o  (state_out),
    .busy_o   (busy),
    .done_o   (done)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit cmp_en  = 1'b0;

  localparam logic [319:0] T2_VEC = {64'h00001000808c0001, 64'h6cb10ad9ca912f80,
                                     64'h691aed630e81901f, 64'h0c4c36a20853217c,
                                     64'h46487b3e06d9d7a8};

  localparam logic [4:0] SBOX [32] = '{
    5'd4,  5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9,  5'd2,
    5'd27, 5'd5,  5'd8,  5'd18, 5'd29, 5'd3,  5'd6,  5'd28,
    5'd30, 5'd19, 5'd7,  5'd14, 5'd0,  5'd13, 5'd17, 5'd24,
    5'd16, 5'd12, 5'd1,  5'd25, 5'd22, 5'd10, 5'd15, 5'd23};

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  function automatic logic [319:0] rand320();
    logic [319:0] r = '0;
    for (int i = 0; i < 10; i++) r = {r[287:0], $urandom()};
    return r;
  endfunction

  // ---------------- reference model: ASCON round from its definition -------
  function automatic logic [7:0] m_const(input int r);
    return 8'((15 - r) * 16 + r);
  endfunction

  function automatic logic [319:0] m_add_const(input logic [319:0] s, input int r);
    logic [319:0] o = s;
    o[135:128] = s[135:128] ^ m_const(r);
    return o;
  endfunction

  function automatic logic [319:0] m_sub_layer(input logic [319:0] s);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  idx;
    logic [4:0]  v;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    for (int b = 0; b < 64; b++) begin
      idx = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
      v   = SBOX[idx];
      for (int i = 0; i < 5; i++) y[i][b] = v[4 - i];
    end
    return {y[0], y[1], y[2], y[3], y[4]};
  endfunction

  function automatic logic [63:0] m_rotr(input logic [63:0] w, input int n);
    return (w >> n) | (w << (64 - n));
  endfunction

  function automatic logic [319:0] m_lin_layer(input logic [319:0] s);
    int ra [5] = '{19, 61, 1, 10, 7};
    int rb [5] = '{28, 39, 6, 17, 41};
    logic [63:0] w;
    logic [319:0] o;
    for (int i = 0; i < 5; i++) begin
      w = s[319 - 64*i -: 64];
      o[319 - 64*i -: 64] = w ^ m_rotr(w, ra[i]) ^ m_rotr(w, rb[i]);
    end
    return o;
  endfunction

  function automatic logic [319:0] m_permute(input logic [319:0] s, input int first_r, input int count);
    logic [319:0] x = s;
    for (int k = 0; k < count; k++) x = m_lin_layer(m_sub_layer(m_add_const(x, first_r + k)));
    return x;
  endfunction

  // ---------------- reference model: schedule by elapsed cycles ------------
  // m_t = edges since the accepting edge. Rounds applied = min(m_t, m_n);
  // done when m_t == m_n; a new start is accepted once m_t reaches m_n+1.
  bit           m_active = 1'b0;
  int           m_t = 0;
  int           m_n = 12;
  logic [319:0] m_in = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_n      <= 12;
      m_in     <= '0;
    end else if ((!m_active || m_t >= m_n + 1) && start) begin
      m_active <= 1'b1;
      m_t      <= 0;
      m_n      <= sel_b ? 6 : 12;
      m_in     <= state_in;
    end else if (m_active && m_t < m_n + 1) begin
      m_t <= m_t + 1;
    end
  end

  // ---------------- compare process ----------------------------------------
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("model_busy", 320'(busy), 320'(m_active && m_t < m_n));
      check("model_done", 320'(done), 320'(m_active && m_t == m_n));
      check("model_state", state_out,
            m_active ? m_permute(m_in, 12 - m_n, (m_t < m_n) ? m_t : m_n) : 320'h0);
    end
  end

  // ---------------- directed helpers ---------------------------------------
  task automatic run_one(input logic [319:0] v, input bit sel);
    int n = sel ? 6 : 12;
    int cnt;
    int busy_cycles;
    @(negedge clk);
    start = 1'b1; sel_b = sel; state_in = v;
    @(negedge clk);
    start = 1'b0; sel_b = 1'($urandom()); state_in = rand320();
    check("probe_pc", dut.pc_state, m_add_const(v, 12 - n));
    cnt = 1; busy_cycles = 0;
    while (!done && cnt < 40) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      cnt++;
    end
    check("latency", 320'(cnt), 320'(n + 1));
    check("busy_cycles", 320'(busy_cycles), 320'(n));
    check("result", state_out, m_permute(v, 12 - n, n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int done_times [$];
    int cnt;
    logic [319:0] exp12;

    // T1: reset holds everything at zero, start ignored
    repeat (2) @(negedge clk);
    start = 1'b1; state_in = rand320();
    @(negedge clk);
    start = 1'b0;
    check("rst_state", state_out, 320'h0);
    check("rst_busy", 320'(busy), 320'h0);
    check("rst_done", 320'(done), 320'h0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", 320'({busy, done}), 320'h0);

    // Pins on the model itself
    check("pin_c0", 320'(m_const(0)), 320'h0F0);
    check("pin_c6", 320'(m_const(6)), 320'h096);
    check("pin_c11", 320'(m_const(11)), 320'h04B);
    check("pin_pc_r0", m_add_const(T2_VEC, 0),
          {T2_VEC[319:192], 64'h691aed630e8190ef, T2_VEC[127:0]});
    check("pin_pc_r6", m_add_const(T2_VEC, 6),
          {T2_VEC[319:192], 64'h691aed630e819089, T2_VEC[127:0]});
    check("pin_sbox_zero", m_sub_layer(320'h0), {128'h0, 64'hFFFFFFFFFFFFFFFF, 128'h0});
    check("pin_sbox_x0", m_sub_layer({64'hFFFFFFFFFFFFFFFF, 256'h0}),
          {{4{64'hFFFFFFFFFFFFFFFF}}, 64'h0});
    check("pin_lin_s0", m_lin_layer({64'h1, 256'h0}), {64'h0000201000000001, 256'h0});

    // T2 / T3: p^12 and p^6 on the reference vector, with literal probes
    @(negedge clk);
    start = 1'b1; sel_b = 1'b0; state_in = T2_VEC;
    @(negedge clk);
    start = 1'b0;
    check("t2_probe_lit", dut.pc_state, {T2_VEC[319:192], 64'h691aed630e8190ef, T2_VEC[127:0]});
    repeat (14) @(negedge clk);
    run_one(T2_VEC, 1'b0);
    @(negedge clk);
    start = 1'b1; sel_b = 1'b1; state_in = T2_VEC;
    @(negedge clk);
    start = 1'b0;
    check("t3_probe_lit", dut.pc_state, {T2_VEC[319:192], 64'h691aed630e819089, T2_VEC[127:0]});
    repeat (8) @(negedge clk);
    run_one(T2_VEC, 1'b1);

    // T4: starts during RUN and DONE are ignored
    exp12 = m_permute(T2_VEC, 0, 12);
    @(negedge clk);
    start = 1'b1; sel_b = 1'b0; state_in = T2_VEC;
    cnt = 0;
    do begin
      @(negedge clk);
      start = 1'($urandom()); sel_b = 1'($urandom()); state_in = rand320();
      cnt++;
    end while (!done && cnt < 40);
    start = 1'b1;
    check("t4_result", state_out, exp12);
    @(negedge clk);
    start = 1'b0;
    check("t4_hold", state_out, exp12);
    check("t4_idle", 320'({busy, done}), 320'h0);

    // T5: reset mid-run clears asynchronously, then a fresh run completes
    @(negedge clk);
    start = 1'b1; sel_b = 1'b0; state_in = rand320();
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_state", state_out, 320'h0);
    check("t5_busy", 320'(busy), 320'h0);
    check("t5_done", 320'(done), 320'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_one(rand320(), 1'b0);

    // T6: start held high, state_i re-sampled for each run
    @(negedge clk);
    start = 1'b1; sel_b = 1'b0;
    for (int c = 0; c < 70; c++) begin
      state_in = rand320();
      @(negedge clk);
      if (done) done_times.push_back(c);
    end
    start = 1'b0;
    check("t6_done_count", 320'(done_times.size() >= 4), 320'h1);
    for (int i = 1; i < done_times.size(); i++)
      check("t6_period", 320'(done_times[i] - done_times[i-1]), 320'd14);
    repeat (16) @(negedge clk);

    // Randomised traffic: starts, selects and states at random
    for (int c = 0; c < 600; c++) begin
      start    = ($urandom_range(3) == 0);
      sel_b    = 1'($urandom());
      state_in = rand320();
      @(negedge clk);
    end
    start = 1'b0;
    repeat (16) @(negedge clk);
    check("final_idle", 320'({busy, done}), 320'h0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
